mips_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- One shared memory port with a req/ack handshake replaces the separate instruction and data memories; XLEN is selectable (32 or 64).
- An explicit FSM sequences fetch/decode/execute/memory/writeback and tolerates variable memory latency; a halt instruction stops the core.
- Sits under the system top; connects to a unified word-addressed memory.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_regfile.sv | 35 +++
 rtl/mips_multicycle_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, function codes,
// FSM state encoding and ALU operation codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    // True for the R-type function codes the core implements.
    function automatic logic funct_known(input logic [5:0] funct);
        logic known;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: known = 1'b1;
            default:                               known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port. Register 0 always reads as zero and ignores writes.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_r [32];

    // Register storage: cleared on reset, written on enable except for r0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? {XLEN{1'b0}} : regs_r[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? {XLEN{1'b0}} : regs_r[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with a single shared req/ack memory port. One
// instruction is in flight at a time; memory outputs are registered and are
// derived from the next FSM state so a request is presented in the first
// cycle of FETCH/MEM and held until acknowledged.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            halted,
    output logic [AW-1:0]   dbg_pc
);

    state_t          state_r, next_state_s;
    logic [AW-1:0]   pc_r, pc_next_s;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] a_r, b_r, imm_r, alu_out_r, mdr_r;

    logic            mem_req_r, mem_we_r, halted_r;
    logic [AW-1:0]   mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;

    logic            req_next_s, we_next_s, halted_next_s;
    logic [AW-1:0]   addr_next_s;
    logic [XLEN-1:0] wdata_next_s, alu_next_s;

    logic [5:0]      op_s, funct_s;
    logic [4:0]      rs_s, rt_s, rd_s;
    logic [XLEN-1:0] imm_sext_s, rdata_a_s, rdata_b_s, alu_b_s, alu_result_s;
    logic [AW-1:0]   jump_target_s, branch_target_s;
    logic            ack_s, is_rtype_s, is_j_s, is_halt_s, is_lw_s, is_sw_s;
    logic            is_branch_s, branch_taken_s, op_known_s;
    alu_op_t         alu_op_s;

    assign op_s       = ir_r[31:26];
    assign rs_s       = ir_r[25:21];
    assign rt_s       = ir_r[20:16];
    assign rd_s       = ir_r[15:11];
    assign funct_s    = ir_r[5:0];
    assign imm_sext_s = {{(XLEN-16){ir_r[15]}}, ir_r[15:0]};

    assign is_rtype_s  = (op_s == OP_RTYPE);
    assign is_j_s      = (op_s == OP_J);
    assign is_halt_s   = (op_s == OP_HALT);
    assign is_lw_s     = (op_s == OP_LW);
    assign is_sw_s     = (op_s == OP_SW);
    assign is_branch_s = (op_s == OP_BEQ) || (op_s == OP_BNE);

    // An ack only counts while a request is actually outstanding.
    assign ack_s = mem_req_r && mem_ack;

    assign jump_target_s   = AW'(ir_r[25:0]);
    assign branch_target_s = pc_r + AW'(imm_r);

    mips_regfile #(.XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s),
        .we      (state_r == ST_WB),
        .waddr   (is_rtype_s ? rd_s : rt_s),
        .wdata   (is_lw_s ? mdr_r : alu_out_r)
    );

    // Classify the opcode/funct pair as implemented or not
    always_comb begin
        op_known_s = 1'b0;
        case (op_s)
            OP_RTYPE:                                 op_known_s = funct_known(funct_s);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: op_known_s = 1'b1;
            default:                                  op_known_s = 1'b0;
        endcase
    end

    // Select the ALU operation: R-type by funct, everything else adds
    always_comb begin
        alu_op_s = ALU_ADD;
        if (is_rtype_s) begin
            case (funct_s)
                FN_SUB:  alu_op_s = ALU_SUB;
                FN_AND:  alu_op_s = ALU_AND;
                FN_OR:   alu_op_s = ALU_OR;
                FN_SLT:  alu_op_s = ALU_SLT;
                default: alu_op_s = ALU_ADD;
            endcase
        end else begin
            alu_op_s = ALU_ADD;
        end
    end

    // ALU: wrapping arithmetic, logic ops and signed set-less-than
    always_comb begin
        alu_b_s      = is_rtype_s ? b_r : imm_r;
        alu_result_s = {XLEN{1'b0}};
        case (alu_op_s)
            ALU_ADD: alu_result_s = a_r + alu_b_s;
            ALU_SUB: alu_result_s = a_r - alu_b_s;
            ALU_AND: alu_result_s = a_r & alu_b_s;
            ALU_OR:  alu_result_s = a_r | alu_b_s;
            ALU_SLT: alu_result_s = ($signed(a_r) < $signed(alu_b_s)) ?
                                    {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
            default: alu_result_s = {XLEN{1'b0}};
        endcase
    end

    // Branch condition evaluated on the latched operands
    always_comb begin
        branch_taken_s = 1'b0;
        if (op_s == OP_BEQ) begin
            branch_taken_s = (a_r == b_r);
        end else if (op_s == OP_BNE) begin
            branch_taken_s = (a_r != b_r);
        end else begin
            branch_taken_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; waits in FETCH/MEM until the memory acknowledges
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH:  next_state_s = ack_s ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (is_j_s) begin
                    next_state_s = ST_FETCH;
                end else if (is_halt_s || !op_known_s) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_lw_s || is_sw_s) begin
                    next_state_s = ST_MEM;
                end else if (is_branch_s) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (ack_s) begin
                    next_state_s = is_lw_s ? ST_WB : ST_FETCH;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = ST_FETCH;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_HALT;
        endcase
    end

    // Next PC: increment on fetch ack, jump target in decode, branch in exec
    always_comb begin
        pc_next_s = pc_r;
        case (state_r)
            ST_FETCH:  pc_next_s = ack_s ? (pc_r + AW'(1'b1)) : pc_r;
            ST_DECODE: pc_next_s = is_j_s ? jump_target_s : pc_r;
            ST_EXEC:   pc_next_s = branch_taken_s ? branch_target_s : pc_r;
            default:   pc_next_s = pc_r;
        endcase
    end

    // FSM outputs: next values of the registered memory port and halt flag.
    // The request always drops for one cycle after an ack.
    always_comb begin
        alu_next_s    = (state_r == ST_EXEC) ? alu_result_s : alu_out_r;
        req_next_s    = ((next_state_s == ST_FETCH) || (next_state_s == ST_MEM)) && !ack_s;
        we_next_s     = 1'b0;
        addr_next_s   = {AW{1'b0}};
        wdata_next_s  = {XLEN{1'b0}};
        halted_next_s = (next_state_s == ST_HALT);
        if (req_next_s && (next_state_s == ST_MEM)) begin
            addr_next_s  = alu_next_s[AW-1:0];
            we_next_s    = is_sw_s;
            wdata_next_s = is_sw_s ? b_r : {XLEN{1'b0}};
        end else if (req_next_s) begin
            addr_next_s  = pc_next_s;
        end else begin
            addr_next_s  = {AW{1'b0}};
        end
    end

    // Registered memory-port and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            halted_r    <= 1'b0;
        end else begin
            mem_req_r   <= req_next_s;
            mem_we_r    <= we_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            halted_r    <= halted_next_s;
        end
    end

    // Datapath registers: PC, instruction, operand latches, ALU result, load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= RESET_PC;
            ir_r      <= 32'd0;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            imm_r     <= {XLEN{1'b0}};
            alu_out_r <= {XLEN{1'b0}};
            mdr_r     <= {XLEN{1'b0}};
        end else begin
            pc_r <= pc_next_s;
            if ((state_r == ST_FETCH) && ack_s) begin
                ir_r <= mem_rdata[31:0];
            end
            if (state_r == ST_DECODE) begin
                a_r   <= rdata_a_s;
                b_r   <= rdata_b_s;
                imm_r <= imm_sext_s;
            end
            if (state_r == ST_EXEC) begin
                alu_out_r <= alu_result_s;
            end
            if ((state_r == ST_MEM) && ack_s && is_lw_s) begin
                mdr_r <= mem_rdata;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign halted    = halted_r;
    assign dbg_pc    = pc_r;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core (XLEN=64, AW=16). Each program's
// expected bus transactions are queued before it runs; a monitor pops and
// compares on every acknowledged request and checks request stability.
module tb_mips_multicycle_core;

    localparam int XLEN = 64;
    localparam int AW   = 16;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mem_req, mem_we, halted;
    logic [AW-1:0]   mem_addr, dbg_pc;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            mem_ack = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    int   waits = 0;
    bit   spurious_ack = 1'b0;
    int   wait_cnt = 0;
    txn_t exp_q[$];
    logic [XLEN-1:0] mem [int];

    always #5 clk = ~clk;

    mips_multicycle_core #(.XLEN(XLEN), .AW(AW), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .dbg_pc    (dbg_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

    task automatic load(input int a, input logic [31:0] w);
        mem[a] = XLEN'(w);
    endtask

    task automatic push_rd(input int a);
        txn_t t;
        t.we = 1'b0; t.addr = AW'(a); t.wdata = '0;
        exp_q.push_back(t);
    endtask

    task automatic push_wr(input int a, input logic [XLEN-1:0] d);
        txn_t t;
        t.we = 1'b1; t.addr = AW'(a); t.wdata = d;
        exp_q.push_back(t);
    endtask

    // Memory responder: acks after 'waits' cycles, optional stray acks when idle
    always @(negedge clk) begin
        if (!mem_req) begin
            wait_cnt = 0;
            mem_ack  = spurious_ack;
        end else if (wait_cnt >= waits) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            if (mem_we) begin
                mem[int'(mem_addr)] = mem_wdata;
            end else begin
                mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : '0;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    // Monitor: request stability while waiting, scoreboard compare on ack
    txn_t snap;
    bit   active = 1'b0;
    always begin
        txn_t e;
        @(negedge clk);
        #1;
        if (rst && mem_req) begin
            if (active) begin
                check("req_stable", {mem_we, mem_addr, mem_wdata}, snap);
            end else begin
                snap   = {mem_we, mem_addr, mem_wdata};
                active = 1'b1;
            end
            if (mem_ack) begin
                active = 1'b0;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL txn_unexpected: got we=%b addr=%h, required no transaction", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_we", 64'(mem_we), 64'(e.we));
                    check("txn_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) check("txn_wdata", mem_wdata, e.wdata);
                end
            end
        end else begin
            active = 1'b0;
        end
    end

    // Reset, check reset outputs, release and wait (bounded) for halt
    task automatic run_prog(input int n_waits, input bit spur, output int cycles);
        waits = n_waits;
        spurious_ack = spur;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_pc", 64'(dbg_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!halted && cycles < 2000);
        #2;
        check("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic finish_prog(input int exp_pc);
        repeat (3) @(negedge clk);
        #2;
        check("halt_pc", 64'(dbg_pc), 64'(exp_pc));
        check("halt_no_req", 64'(mem_req), 64'd0);
        check("txn_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        bit found;

        // Program 1: add of two immediates, zero-wait, halt timing
        mem.delete();
        load(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        load(1, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        load(2, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        load(3, HALT_W);
        for (int i = 0; i < 4; i++) push_rd(i);
        run_prog(0, 1'b0, cyc);
        check("halt_cycle", 64'(cyc), 64'd15);
        finish_prog(4);

        // Program 2: all ALU ops stored out, write to r0 discarded
        mem.delete();
        load(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        load(1,  enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        load(2,  enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        load(3,  enc_i(6'h2B, 5'd0, 5'd3, 16'd200));
        load(4,  enc_r(5'd1, 5'd2, 5'd4, 6'h22));
        load(5,  enc_r(5'd1, 5'd2, 5'd5, 6'h24));
        load(6,  enc_r(5'd1, 5'd2, 5'd6, 6'h25));
        load(7,  enc_r(5'd2, 5'd1, 5'd7, 6'h2A));
        load(8,  enc_i(6'h2B, 5'd0, 5'd4, 16'd201));
        load(9,  enc_i(6'h2B, 5'd0, 5'd5, 16'd202));
        load(10, enc_i(6'h2B, 5'd0, 5'd6, 16'd203));
        load(11, enc_i(6'h2B, 5'd0, 5'd7, 16'd204));
        load(12, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        load(13, enc_i(6'h2B, 5'd0, 5'd0, 16'd205));
        load(14, HALT_W);
        for (int i = 0; i < 4; i++) push_rd(i);
        push_wr(200, 64'd2);
        for (int i = 4; i < 9; i++) push_rd(i);
        push_wr(201, 64'd8);
        push_rd(9);  push_wr(202, 64'd5);
        push_rd(10); push_wr(203, 64'hFFFF_FFFF_FFFF_FFFD);
        push_rd(11); push_wr(204, 64'd1);
        push_rd(12);
        push_rd(13); push_wr(205, 64'd0);
        push_rd(14);
        run_prog(0, 1'b0, cyc);
        finish_prog(15);

        // Program 3: sw then lw with 3 wait cycles and stray idle acks
        mem.delete();
        load(0, enc_i(6'h08, 5'd0, 5'd1, 16'h1234));
        load(1, enc_i(6'h2B, 5'd0, 5'd1, 16'd100));
        load(2, enc_i(6'h23, 5'd0, 5'd4, 16'd100));
        load(3, enc_i(6'h2B, 5'd0, 5'd4, 16'd101));
        load(4, HALT_W);
        push_rd(0); push_rd(1); push_wr(100, 64'h1234);
        push_rd(2); push_rd(100);
        push_rd(3); push_wr(101, 64'h1234);
        push_rd(4);
        run_prog(3, 1'b1, cyc);
        finish_prog(5);

        // Program 4: branches taken/not taken and PC wrap at 0xFFFF
        mem.delete();
        load(0,  enc_j(26'd20));
        load(1,  HALT_W);
        load(20, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
        load(21, enc_j(26'd10));
        load(10, enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE));
        load(9,  enc_i(6'h08, 5'd0, 5'd2, 16'd1));
        load(11, enc_i(6'h04, 5'd1, 5'd0, 16'd7));
        load(12, enc_j(26'h00FFFF));
        load(16'hFFFF, enc_i(6'h04, 5'd0, 5'd0, 16'd1));
        push_rd(0); push_rd(20); push_rd(21); push_rd(10); push_rd(9);
        push_rd(10); push_rd(11); push_rd(12); push_rd(16'hFFFF); push_rd(1);
        run_prog(0, 1'b0, cyc);
        finish_prog(2);

        // Program 5: 64-bit all-ones and signed slt
        mem.delete();
        load(0, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
        load(1, enc_r(5'd1, 5'd0, 5'd2, 6'h2A));
        load(2, enc_i(6'h2B, 5'd0, 5'd1, 16'd300));
        load(3, enc_i(6'h2B, 5'd0, 5'd2, 16'd301));
        load(4, HALT_W);
        push_rd(0); push_rd(1);
        push_rd(2); push_wr(300, 64'hFFFF_FFFF_FFFF_FFFF);
        push_rd(3); push_wr(301, 64'd1);
        push_rd(4);
        run_prog(1, 1'b0, cyc);
        finish_prog(5);

        // Program 6: unknown opcode halts before the following store
        mem.delete();
        load(0, enc_i(6'h08, 5'd0, 5'd5, 16'd9));
        load(1, {6'h3E, 5'd0, 5'd5, 16'd1});
        load(2, enc_i(6'h2B, 5'd0, 5'd5, 16'd7));
        push_rd(0); push_rd(1);
        run_prog(0, 1'b0, cyc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            check("unk_no_req", 64'(mem_req), 64'd0);
        end
        finish_prog(2);

        // Program 7: reset while lw waits for ack
        mem.delete();
        load(0, enc_i(6'h23, 5'd0, 5'd4, 16'd100));
        load(1, HALT_W);
        mem[100] = 64'h55;
        push_rd(0);
        waits = 3;
        spurious_ack = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #2;
            if (mem_req && !mem_we && mem_addr == 16'd100 && !mem_ack) found = 1'b1;
        end
        check("lw_req_seen", 64'(found), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_req", 64'(mem_req), 64'd0);
        check("async_we", 64'(mem_we), 64'd0);
        check("async_addr", 64'(mem_addr), 64'd0);
        check("async_pc", 64'(dbg_pc), 64'd0);
        check("txn_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        mem.delete();
        load(0, enc_i(6'h2B, 5'd0, 5'd4, 16'd60));
        load(1, HALT_W);
        push_rd(0); push_wr(60, 64'd0); push_rd(1);
        run_prog(3, 1'b0, cyc);
        finish_prog(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
